// File: rtl/slice_output_stage.sv
// Slice output stage: selects LUT or carry-sum per bit, optionally registered,
// with a serially loaded configuration shift chain.
module slice_output_stage #(
  parameter int unsigned INPUTS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] lut_out,
  input  logic [INPUTS-1:0] cc_s,
  input  logic              cc_co,
  input  logic              ce,
  input  logic              sr,
  input  logic              cset,
  input  logic              cin,
  output logic              cout,
  output logic [INPUTS-1:0] out,
  output logic              co_out
);

  localparam int unsigned CFG_W = 2 * INPUTS + 2;

  logic [CFG_W-1:0]  cfg_q, cfg_d;
  logic [INPUTS-1:0] q_q, q_d;
  logic              qco_q, qco_d;

  logic [INPUTS-1:0] sum_sel;
  logic [INPUTS-1:0] reg_sel;
  logic              co_reg;
  logic              sr_en;
  logic [INPUTS-1:0] d;

  assign sum_sel = cfg_q[INPUTS-1:0];
  assign reg_sel = cfg_q[2*INPUTS-1:INPUTS];
  assign co_reg  = cfg_q[2*INPUTS];
  assign sr_en   = cfg_q[2*INPUTS+1];

  always_comb begin
    for (int i = 0; i < int'(INPUTS); i++) begin
      d[i]   = sum_sel[i] ? cc_s[i] : lut_out[i];
      out[i] = reg_sel[i] ? q_q[i] : d[i];
    end
  end

  assign co_out = co_reg ? qco_q : cc_co;
  assign cout   = cfg_q[CFG_W-1];

  // Data flops are frozen while configuration is shifting.
  always_comb begin
    cfg_d = cfg_q;
    q_d   = q_q;
    qco_d = qco_q;
    if (cset) begin
      cfg_d = {cfg_q[CFG_W-2:0], cin};
    end else if (sr_en && sr) begin
      q_d   = '0;
      qco_d = 1'b0;
    end else if (ce) begin
      q_d   = d;
      qco_d = cc_co;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_q <= '0;
      q_q   <= '0;
      qco_q <= 1'b0;
    end else begin
      cfg_q <= cfg_d;
      q_q   <= q_d;
      qco_q <= qco_d;
    end
  end

endmodule

// File: tb/tb_slice_output_stage.sv
// Directed self-checking bench for slice_output_stage.
module tb_slice_output_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] lut_out;
  logic [3:0] cc_s;
  logic       cc_co;
  logic       ce;
  logic       sr;
  logic       cset;
  logic       cin;
  logic       cout;
  logic [3:0] out;
  logic       co_out;

  int errors = 0;
  int checks = 0;

  slice_output_stage #(.INPUTS(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lut_out(lut_out),
    .cc_s   (cc_s),
    .cc_co  (cc_co),
    .ce     (ce),
    .sr     (sr),
    .cset   (cset),
    .cin    (cin),
    .cout   (cout),
    .out    (out),
    .co_out (co_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts v MSB-first; emitted collects cout as seen before each shifting edge.
  task automatic shift_cfg(input logic [9:0] v, output logic [9:0] emitted);
    cset = 1'b1;
    for (int k = 9; k >= 0; k--) begin
      cin = v[k];
      #1;
      emitted[k] = cout;
      tick();
    end
    cset = 1'b0;
    cin  = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lut_out = 4'b0000; cc_s = 4'b0000; cc_co = 1'b0;
    ce = 1'b0; sr = 1'b0; cset = 1'b0; cin = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    lut_out = 4'b1010; cc_s = 4'b0101; cc_co = 1'b1;
    #1;
    checks++;
    if (out !== 4'b1010) begin
      errors++; $display("FAIL reset_out: got %b expected %b", out, 4'b1010);
    end
    checks++;
    if (co_out !== 1'b1) begin
      errors++; $display("FAIL reset_co_out: got %b expected %b", co_out, 1'b1);
    end
    checks++;
    if (cout !== 1'b0) begin
      errors++; $display("FAIL reset_cout: got %b expected %b", cout, 1'b0);
    end
  endtask

  task automatic test_comb_sum();
    logic [9:0] em;
    shift_cfg(10'b00_0000_1111, em);
    checks++;
    if (em !== 10'b0) begin
      errors++; $display("FAIL comb_emit: got %b expected %b", em, 10'b0);
    end
    checks++;
    if (out !== 4'b0101) begin
      errors++; $display("FAIL comb_sum_out: got %b expected %b", out, 4'b0101);
    end
    cc_s = 4'b0011;
    #1;
    checks++;
    if (out !== 4'b0011) begin
      errors++; $display("FAIL comb_sum_same_cycle: got %b expected %b", out, 4'b0011);
    end
  endtask

  task automatic test_registered();
    logic [9:0] em;
    shift_cfg(10'b01_1111_1111, em);
    checks++;
    if (em !== 10'b00_0000_1111) begin
      errors++; $display("FAIL reg_emit: got %b expected %b", em, 10'b00_0000_1111);
    end
    ce = 1'b1; cc_s = 4'b1100; cc_co = 1'b1;
    #1;
    // Before the capturing edge the registered view still shows the cleared flops.
    checks++;
    if (out !== 4'b0000 || co_out !== 1'b0) begin
      errors++; $display("FAIL reg_before_edge: got %b/%b expected 0000/0", out, co_out);
    end
    tick();
    ce = 1'b0; cc_s = 4'b0000; cc_co = 1'b0;
    #1;
    checks++;
    if (out !== 4'b1100 || co_out !== 1'b1) begin
      errors++; $display("FAIL reg_capture: got %b/%b expected 1100/1", out, co_out);
    end
    lut_out = 4'b0110; cc_s = 4'b1111; cc_co = 1'b0;
    tick();
    tick();
    checks++;
    if (out !== 4'b1100 || co_out !== 1'b1) begin
      errors++; $display("FAIL reg_hold_ce0: got %b/%b expected 1100/1", out, co_out);
    end
  endtask

  task automatic test_sync_clear();
    logic [9:0] em;
    shift_cfg(10'b11_1111_1111, em);
    checks++;
    if (out !== 4'b1100 || co_out !== 1'b1) begin
      errors++; $display("FAIL clr_hold_after_shift: got %b/%b expected 1100/1", out, co_out);
    end
    sr = 1'b1; ce = 1'b1; cc_s = 4'b1010; cc_co = 1'b1;
    tick();
    sr = 1'b0; ce = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0000 || co_out !== 1'b0) begin
      errors++; $display("FAIL clr_sr_en: got %b/%b expected 0000/0", out, co_out);
    end
    shift_cfg(10'b01_1111_1111, em);
    cc_s = 4'b0110; cc_co = 1'b1; sr = 1'b1; ce = 1'b1;
    tick();
    sr = 1'b0; ce = 1'b0;
    #1;
    checks++;
    if (out !== 4'b0110 || co_out !== 1'b1) begin
      errors++; $display("FAIL clr_sr_ignored: got %b/%b expected 0110/1", out, co_out);
    end
  endtask

  task automatic test_shift_hold();
    logic [9:0] em;
    // q=0110, qco=1; data inputs that would disturb the flops if not frozen.
    ce = 1'b1; sr = 1'b1; cc_s = 4'b1001; cc_co = 1'b0; lut_out = 4'b0000;
    shift_cfg(10'h2A5, em);
    ce = 1'b0; sr = 1'b0;
    #1;
    checks++;
    if (em !== 10'b01_1111_1111) begin
      errors++; $display("FAIL hold_emit_old: got %b expected %b", em, 10'b01_1111_1111);
    end
    // 0x2A5: sum_sel=0101, reg_sel=1010, co_reg=0, sr_en=1.
    checks++;
    if (out !== 4'b0011 || co_out !== 1'b0 || cout !== 1'b1) begin
      errors++;
      $display("FAIL hold_new_cfg: got %b/%b/%b expected 0011/0/1", out, co_out, cout);
    end
    shift_cfg(10'b01_1111_1111, em);
    checks++;
    if (em !== 10'h2A5) begin
      errors++; $display("FAIL hold_emit_2a5: got %b expected %b", em, 10'h2A5);
    end
    checks++;
    if (out !== 4'b0110 || co_out !== 1'b1) begin
      errors++; $display("FAIL hold_flops_frozen: got %b/%b expected 0110/1", out, co_out);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [9:0] em;
    cset = 1'b1; cin = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (cout !== 1'b1) begin
      errors++; $display("FAIL mid_shift_cout: got %b expected %b", cout, 1'b1);
    end
    rst_n = 1'b0; ce = 1'b1; cc_s = 4'b1111; cc_co = 1'b1;
    tick();
    rst_n = 1'b1; cset = 1'b0; cin = 1'b0; ce = 1'b0;
    lut_out = 4'b1001; cc_s = 4'b0110; cc_co = 1'b0;
    #1;
    checks++;
    if (out !== 4'b1001 || co_out !== 1'b0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL mid_shift_reset: got %b/%b/%b expected 1001/0/0", out, co_out, cout);
    end
    // Reset must also have won over ce=1 for the data flops.
    shift_cfg(10'b01_1111_1111, em);
    checks++;
    if (em !== 10'b0) begin
      errors++; $display("FAIL mid_shift_cfg_lost: got %b expected %b", em, 10'b0);
    end
    checks++;
    if (out !== 4'b0000 || co_out !== 1'b0) begin
      errors++; $display("FAIL reset_beats_ce: got %b/%b expected 0000/0", out, co_out);
    end
  endtask

  initial begin
    test_reset();
    test_comb_sum();
    test_registered();
    test_sync_clear();
    test_shift_hold();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
